// File: rtl/midi_msg_receiver.sv
// MIDI serial receiver: oversampled UART front end feeding a channel-message parser
// with running status, real-time pass-through, optional channel filter and held-note output.
module midi_msg_receiver #(
    parameter int unsigned CLKS_PER_BIT = 128,
    parameter bit          FILTER_EN    = 1'b0,
    parameter logic [3:0]  CHANNEL      = 4'd0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA,
    output logic [7:0] RX_BYTE,
    output logic       RX_VALID,
    output logic       FRAME_ERR,
    output logic       MSG_VALID,
    output logic [7:0] MSG_STATUS,
    output logic [6:0] MSG_DATA1,
    output logic [6:0] MSG_DATA2,
    output logic [7:0] NOTE
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    logic [1:0]       sync_q, sync_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             rs_valid_q, rs_valid_d;
    logic [7:0]       rs_q, rs_d;
    logic             idx_q, idx_d;
    logic [6:0]       d1_q, d1_d;
    logic             msg_valid_q, msg_valid_d;
    logic [7:0]       msg_status_q, msg_status_d;
    logic [6:0]       msg_data1_q, msg_data1_d;
    logic [6:0]       msg_data2_q, msg_data2_d;
    logic [7:0]       note_q, note_d;

    logic             rx_in;
    logic             one_data;
    logic             complete;
    logic [6:0]       cur_d1, cur_d2;

    assign rx_in = sync_q[1];

    // Serial framing: start qualified at mid-bit, data and stop sampled one bit apart
    always_comb begin
        sync_d      = {sync_q[0], DATA};
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_in) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_in, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_in) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign one_data = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);

    // Message assembly on each received byte; emission and note tracking one cycle later
    always_comb begin
        rs_valid_d   = rs_valid_q;
        rs_d         = rs_q;
        idx_d        = idx_q;
        d1_d         = d1_q;
        msg_valid_d  = 1'b0;
        msg_status_d = msg_status_q;
        msg_data1_d  = msg_data1_q;
        msg_data2_d  = msg_data2_q;
        note_d       = note_q;
        complete     = 1'b0;
        cur_d1       = rx_byte_q[6:0];
        cur_d2       = 7'd0;
        if (frame_err_q) begin
            idx_d = 1'b0;
        end else if (rx_valid_q) begin
            if (rx_byte_q[7]) begin
                if (rx_byte_q[7:3] != 5'b11111) begin
                    rs_valid_d = (rx_byte_q[7:4] != 4'hF);
                    rs_d       = rx_byte_q;
                    idx_d      = 1'b0;
                end
            end else if (rs_valid_q) begin
                if (!idx_q && !one_data) begin
                    d1_d  = rx_byte_q[6:0];
                    idx_d = 1'b1;
                end else begin
                    complete = 1'b1;
                    idx_d    = 1'b0;
                    if (idx_q) begin
                        cur_d1 = d1_q;
                        cur_d2 = rx_byte_q[6:0];
                    end
                end
            end
        end
        if (complete && ((FILTER_EN == 1'b0) || (rs_q[3:0] == CHANNEL))) begin
            msg_valid_d  = 1'b1;
            msg_status_d = rs_q;
            msg_data1_d  = cur_d1;
            msg_data2_d  = cur_d2;
            if ((rs_q[7:4] == 4'h9) && (cur_d2 != 7'd0)) begin
                note_d = {1'b1, cur_d1};
            end else if (((rs_q[7:4] == 4'h8) || (rs_q[7:4] == 4'h9))
                         && note_q[7] && (note_q[6:0] == cur_d1)) begin
                note_d = 8'h00;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q       <= 2'b11;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rs_valid_q   <= 1'b0;
            rs_q         <= '0;
            idx_q        <= 1'b0;
            d1_q         <= '0;
            msg_valid_q  <= 1'b0;
            msg_status_q <= '0;
            msg_data1_q  <= '0;
            msg_data2_q  <= '0;
            note_q       <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rs_valid_q   <= rs_valid_d;
            rs_q         <= rs_d;
            idx_q        <= idx_d;
            d1_q         <= d1_d;
            msg_valid_q  <= msg_valid_d;
            msg_status_q <= msg_status_d;
            msg_data1_q  <= msg_data1_d;
            msg_data2_q  <= msg_data2_d;
            note_q       <= note_d;
        end
    end

    assign RX_BYTE    = rx_byte_q;
    assign RX_VALID   = rx_valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign MSG_VALID  = msg_valid_q;
    assign MSG_STATUS = msg_status_q;
    assign MSG_DATA1  = msg_data1_q;
    assign MSG_DATA2  = msg_data2_q;
    assign NOTE       = note_q;

endmodule

// File: tb/tb_midi_msg_receiver.sv
// Bench for midi_msg_receiver: an unfiltered and a channel-2-filtered instance share one serial line.
module tb_midi_msg_receiver;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic din;

    logic [7:0] rx_byte, msg_status, note;
    logic       rx_valid, frame_err, msg_valid;
    logic [6:0] msg_d1, msg_d2;

    logic [7:0] rx_byte_f, msg_status_f, note_f;
    logic       rx_valid_f, frame_err_f, msg_valid_f;
    logic [6:0] msg_d1_f, msg_d2_f;

    midi_msg_receiver #(.CLKS_PER_BIT(CPB), .FILTER_EN(1'b0), .CHANNEL(4'd0)) dut (
        .CLK(clk), .RESET(rst_n), .DATA(din),
        .RX_BYTE(rx_byte), .RX_VALID(rx_valid), .FRAME_ERR(frame_err),
        .MSG_VALID(msg_valid), .MSG_STATUS(msg_status), .MSG_DATA1(msg_d1),
        .MSG_DATA2(msg_d2), .NOTE(note)
    );

    midi_msg_receiver #(.CLKS_PER_BIT(CPB), .FILTER_EN(1'b1), .CHANNEL(4'd2)) dut_f (
        .CLK(clk), .RESET(rst_n), .DATA(din),
        .RX_BYTE(rx_byte_f), .RX_VALID(rx_valid_f), .FRAME_ERR(frame_err_f),
        .MSG_VALID(msg_valid_f), .MSG_STATUS(msg_status_f), .MSG_DATA1(msg_d1_f),
        .MSG_DATA2(msg_d2_f), .NOTE(note_f)
    );

    typedef struct {
        logic [0:5][7:0] b;
        int              nb;
        int              nm;
        logic [21:0]     m;
        logic [7:0]      note;
        int              nmf;
        logic [21:0]     mf;
        logic [7:0]      note_f;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int fe_cnt   = 0;

    logic [7:0]  exp_byte [$];
    logic [21:0] exp_msg  [$];
    logic [21:0] exp_msgf [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] mm(input logic [7:0] st, input logic [6:0] a, input logic [6:0] c);
        return {st, a, c};
    endfunction

    function automatic vec_t mk(input logic [47:0] b, input int nb, input int nm, input logic [21:0] m,
                                input logic [7:0] nt, input int nmf, input logic [21:0] mf,
                                input logic [7:0] ntf);
        vec_t v;
        v.b = b; v.nb = nb; v.nm = nm; v.m = m; v.note = nt;
        v.nmf = nmf; v.mf = mf; v.note_f = ntf;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (CPB) @(negedge clk);
        end
        din = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_byte.push_back(b);
        send_byte(b, 1'b1);
    endtask

    // Scoreboard: every output pulse must match the head of its expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_cnt++;
                check("rx_expected", 64'(exp_byte.size() != 0), 64'd1);
                if (exp_byte.size() != 0) check("rx_byte", 64'(rx_byte), 64'(exp_byte.pop_front()));
            end
            if (frame_err) fe_cnt++;
            if (msg_valid) begin
                check("msg_expected", 64'(exp_msg.size() != 0), 64'd1);
                if (exp_msg.size() != 0)
                    check("msg", 64'({msg_status, msg_d1, msg_d2}), 64'(exp_msg.pop_front()));
            end
            if (msg_valid_f) begin
                check("msgf_expected", 64'(exp_msgf.size() != 0), 64'd1);
                if (exp_msgf.size() != 0)
                    check("msgf", 64'({msg_status_f, msg_d1_f, msg_d2_f}), 64'(exp_msgf.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [0:12];
    int   rx0, fe0;

    initial begin
        vecs[0]  = mk({8'h90,8'h3C,8'h64,8'h00,8'h00,8'h00}, 3, 1, mm(8'h90,7'h3C,7'h64), 8'hBC, 0, 22'h0, 8'h00);
        vecs[1]  = mk({8'h40,8'h50,8'h00,8'h00,8'h00,8'h00}, 2, 1, mm(8'h90,7'h40,7'h50), 8'hC0, 0, 22'h0, 8'h00);
        vecs[2]  = mk({8'h40,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 1, mm(8'h90,7'h40,7'h00), 8'h00, 0, 22'h0, 8'h00);
        vecs[3]  = mk({8'h90,8'h3C,8'hF8,8'h64,8'h00,8'h00}, 4, 1, mm(8'h90,7'h3C,7'h64), 8'hBC, 0, 22'h0, 8'h00);
        vecs[4]  = mk({8'hC5,8'h07,8'h00,8'h00,8'h00,8'h00}, 2, 1, mm(8'hC5,7'h07,7'h00), 8'hBC, 0, 22'h0, 8'h00);
        vecs[5]  = mk({8'h91,8'h3C,8'h64,8'h00,8'h00,8'h00}, 3, 1, mm(8'h91,7'h3C,7'h64), 8'hBC, 0, 22'h0, 8'h00);
        vecs[6]  = mk({8'h92,8'h3C,8'h64,8'h00,8'h00,8'h00}, 3, 1, mm(8'h92,7'h3C,7'h64), 8'hBC,
                      1, mm(8'h92,7'h3C,7'h64), 8'hBC);
        vecs[7]  = mk({8'h82,8'h3D,8'h40,8'h00,8'h00,8'h00}, 3, 1, mm(8'h82,7'h3D,7'h40), 8'hBC,
                      1, mm(8'h82,7'h3D,7'h40), 8'hBC);
        vecs[8]  = mk({8'h3D,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 1, mm(8'h82,7'h3D,7'h00), 8'hBC,
                      1, mm(8'h82,7'h3D,7'h00), 8'hBC);
        vecs[9]  = mk({8'hF0,8'h01,8'h02,8'hF7,8'h00,8'h00}, 4, 0, 22'h0, 8'hBC, 0, 22'h0, 8'hBC);
        vecs[10] = mk({8'h10,8'h20,8'h00,8'h00,8'h00,8'h00}, 2, 0, 22'h0, 8'hBC, 0, 22'h0, 8'hBC);
        vecs[11] = mk({8'hB2,8'h07,8'h92,8'h3C,8'h00,8'h00}, 5, 1, mm(8'h92,7'h3C,7'h00), 8'h00,
                      1, mm(8'h92,7'h3C,7'h00), 8'h00);
        vecs[12] = mk({8'hD2,8'h55,8'h00,8'h00,8'h00,8'h00}, 2, 1, mm(8'hD2,7'h55,7'h00), 8'h00,
                      1, mm(8'hD2,7'h55,7'h00), 8'h00);

        din   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rx_byte, rx_valid, frame_err, msg_valid, msg_status, msg_d1, msg_d2}), 64'd0);
        check("reset_note", 64'({note, note_f}), 64'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Table vectors, bytes sent back-to-back with no idle bits
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].nm != 0)  exp_msg.push_back(vecs[i].m);
            if (vecs[i].nmf != 0) exp_msgf.push_back(vecs[i].mf);
            for (int k = 0; k < vecs[i].nb; k++) send_good(vecs[i].b[k]);
            repeat (6) @(negedge clk);
            check($sformatf("note_v%0d", i), 64'(note), 64'(vecs[i].note));
            check($sformatf("note_f_v%0d", i), 64'(note_f), 64'(vecs[i].note_f));
        end

        // Short low glitch is rejected
        rx0 = rx_cnt; fe0 = fe_cnt;
        din = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        din = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_rx", 64'(rx_cnt - rx0), 64'd0);
        check("glitch_fe", 64'(fe_cnt - fe0), 64'd0);
        send_good(8'hF8);
        repeat (6) @(negedge clk);
        check("post_glitch_rx", 64'(rx_cnt - rx0), 64'd1);

        // Bad stop bit drops the byte and the partial message but keeps running status
        rx0 = rx_cnt; fe0 = fe_cnt;
        exp_msg.push_back(mm(8'h90, 7'h64, 7'h22));
        send_good(8'h90);
        send_good(8'h3C);
        send_byte(8'h64, 1'b0);
        din = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("framing_fe", 64'(fe_cnt - fe0), 64'd1);
        check("framing_rx", 64'(rx_cnt - rx0), 64'd2);
        send_good(8'h64);
        send_good(8'h22);
        repeat (6) @(negedge clk);
        check("framing_note", 64'(note), 64'hE4);
        check("framing_note_f", 64'(note_f), 64'h00);

        // Line held low for three frame times gives one frame error and no bytes
        rx0 = rx_cnt; fe0 = fe_cnt;
        din = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        din = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break_fe", 64'(fe_cnt - fe0), 64'd1);
        check("break_rx", 64'(rx_cnt - rx0), 64'd0);

        // Reset in the middle of a byte clears outputs at once, without a clock edge
        din = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'({rx_byte, rx_valid, frame_err, msg_valid, msg_status, msg_d1, msg_d2}), 64'd0);
        check("midreset_note", 64'(note), 64'd0);
        din = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rx0 = rx_cnt;
        send_good(8'h3C);
        send_good(8'h40);
        exp_msg.push_back(mm(8'h90, 7'h3C, 7'h64));
        send_good(8'h90);
        send_good(8'h3C);
        send_good(8'h64);
        repeat (6) @(negedge clk);
        check("postreset_rx", 64'(rx_cnt - rx0), 64'd5);
        check("postreset_note", 64'(note), 64'hBC);
        check("postreset_note_f", 64'(note_f), 64'h00);

        check("byte_queue_drained", 64'(exp_byte.size()), 64'd0);
        check("msg_queue_drained", 64'(exp_msg.size()), 64'd0);
        check("msgf_queue_drained", 64'(exp_msgf.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
